// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the watch time-setting controller.
// Optional seconds digits are enabled with the SECONDS_EN macro.
package time_set_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EDIT = 1'b1
    } state_t;

    localparam logic [2:0] CUR_H1 = 3'd0;
    localparam logic [2:0] CUR_H0 = 3'd1;
    localparam logic [2:0] CUR_M1 = 3'd2;
    localparam logic [2:0] CUR_M0 = 3'd3;
    localparam logic [2:0] CUR_S1 = 3'd4;
    localparam logic [2:0] CUR_S0 = 3'd5;
`ifdef SECONDS_EN
    localparam logic [2:0] CUR_LAST = CUR_S0;
`else
    localparam logic [2:0] CUR_LAST = CUR_M0;
`endif

    localparam logic [3:0] DIGIT_MIN    = 4'd0;
    localparam logic [3:0] TENS_MAX     = 4'd5;
    localparam logic [3:0] UNITS_MAX    = 4'd9;
    localparam logic [3:0] H1_MAX_24    = 4'd2;
    localparam logic [3:0] H1_MAX_12    = 4'd1;
    localparam logic [3:0] H0_MAX_24_H2 = 4'd3;
    localparam logic [3:0] H0_MAX_12_H1 = 4'd2;
    localparam logic [3:0] H0_MIN_12_H0 = 4'd1;

    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
`ifdef SECONDS_EN
        logic [3:0] s1;
        logic [3:0] s0;
`endif
    } digits_t;

    function automatic logic [3:0] wrap_step(input logic [3:0] v, input logic [3:0] lo,
                                             input logic [3:0] hi, input logic inc);
        if (inc)
            return (v >= hi) ? lo : v + 4'd1;
        else
            return (v <= lo) ? hi : v - 4'd1;
    endfunction

    function automatic logic [3:0] h0_max(input logic [3:0] h1, input logic m24);
        if (m24)
            return (h1 == H1_MAX_24) ? H0_MAX_24_H2 : UNITS_MAX;
        else
            return (h1 == H1_MAX_12) ? H0_MAX_12_H1 : UNITS_MAX;
    endfunction

    function automatic logic [3:0] h0_min(input logic [3:0] h1, input logic m24);
        return (!m24 && h1 == DIGIT_MIN) ? H0_MIN_12_H0 : DIGIT_MIN;
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Front-panel and edit-register bundle for time_set_ctrl.
// SECONDS_EN adds the seconds digits.
interface time_set_ctrl_if;
    logic       start;
    logic       nextDigit;
    logic       up;
    logic       down;
    logic       mode24;
    logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0;
    logic [3:0] h1, h0, m1, m0;
`ifdef SECONDS_EN
    logic [3:0] cur_s1, cur_s0;
    logic [3:0] s1, s0;
`endif
    logic       editing;
    logic [2:0] cursor;
    logic       blank;
    logic       commit;

    modport slave (
        input  start, nextDigit, up, down, mode24, cur_h1, cur_h0, cur_m1, cur_m0,
`ifdef SECONDS_EN
        input  cur_s1, cur_s0,
        output s1, s0,
`endif
        output h1, h0, m1, m0, editing, cursor, blank, commit
    );

    modport master (
        output start, nextDigit, up, down, mode24, cur_h1, cur_h0, cur_m1, cur_m0,
`ifdef SECONDS_EN
        output cur_s1, cur_s0,
        input  s1, s0,
`endif
        input  h1, h0, m1, m0, editing, cursor, blank, commit
    );
endinterface

// File: rtl/time_set_ctrl_edge_detect.sv
// Rising-edge detector for one debounced button level.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prev <= 1'b0;
        else
            prev <= level;
    end

    assign rise = level & ~prev;
endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: loads live time, edits digits with up/down, commits on exit.
// Define SECONDS_EN to add the seconds digits and cursor positions 4-5.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int unsigned BLINK_DIV    = 25_000_000,
    parameter int unsigned IDLE_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            reset,
    time_set_ctrl_if.slave  bus
);

    state_t      state, state_nx;
    digits_t     d;
    logic [2:0]  cursor;
    logic        blank;
    logic        commit;
    logic        m24_q;
    logic [31:0] blink_cnt;
    logic [31:0] idle_cnt;
    logic        start_e, next_e, up_e, down_e, any_edge, timeout;

    edge_detect u_ed_start (.clk(clk), .reset(reset), .level(bus.start),     .rise(start_e));
    edge_detect u_ed_next  (.clk(clk), .reset(reset), .level(bus.nextDigit), .rise(next_e));
    edge_detect u_ed_up    (.clk(clk), .reset(reset), .level(bus.up),        .rise(up_e));
    edge_detect u_ed_down  (.clk(clk), .reset(reset), .level(bus.down),      .rise(down_e));

    assign any_edge = start_e | next_e | up_e | down_e;
    assign timeout  = (IDLE_TIMEOUT != 0) && (state == EDIT) && !any_edge &&
                      (idle_cnt == IDLE_TIMEOUT - 1);

    function automatic digits_t load_cur();
        digits_t r;
        r.h1 = bus.cur_h1;
        r.h0 = bus.cur_h0;
        r.m1 = bus.cur_m1;
        r.m0 = bus.cur_m0;
`ifdef SECONDS_EN
        r.s1 = bus.cur_s1;
        r.s0 = bus.cur_s0;
`endif
        return r;
    endfunction

    // An H1 step re-normalises H0 in the same cycle so the hour is always legal.
    function automatic digits_t step_digit(input digits_t cur_d, input logic [2:0] sel,
                                           input logic inc, input logic m24);
        digits_t r;
        r = cur_d;
        case (sel)
            CUR_H1: begin
                r.h1 = wrap_step(cur_d.h1, DIGIT_MIN, m24 ? H1_MAX_24 : H1_MAX_12, inc);
                if (r.h0 > h0_max(r.h1, m24))
                    r.h0 = h0_max(r.h1, m24);
                if (r.h0 < h0_min(r.h1, m24))
                    r.h0 = h0_min(r.h1, m24);
            end
            CUR_H0: r.h0 = wrap_step(cur_d.h0, h0_min(cur_d.h1, m24), h0_max(cur_d.h1, m24), inc);
            CUR_M1: r.m1 = wrap_step(cur_d.m1, DIGIT_MIN, TENS_MAX, inc);
            CUR_M0: r.m0 = wrap_step(cur_d.m0, DIGIT_MIN, UNITS_MAX, inc);
`ifdef SECONDS_EN
            CUR_S1: r.s1 = wrap_step(cur_d.s1, DIGIT_MIN, TENS_MAX, inc);
            CUR_S0: r.s0 = wrap_step(cur_d.s0, DIGIT_MIN, UNITS_MAX, inc);
`endif
            default: ;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_e) state_nx = EDIT;
            EDIT: if (start_e || timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.editing = (state == EDIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d         <= '0;
            cursor    <= CUR_H1;
            blank     <= 1'b0;
            commit    <= 1'b0;
            m24_q     <= 1'b1;
            blink_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            commit <= 1'b0;
            if (state == IDLE) begin
                blank     <= 1'b0;
                blink_cnt <= '0;
                idle_cnt  <= '0;
                if (start_e) begin
                    d      <= load_cur();
                    m24_q  <= bus.mode24;
                    cursor <= CUR_H1;
                end
            end else if (any_edge) begin
                blank     <= 1'b0;
                blink_cnt <= '0;
                idle_cnt  <= '0;
                if (start_e)
                    commit <= 1'b1;
                else if (next_e)
                    cursor <= (cursor == CUR_LAST) ? CUR_H1 : cursor + 3'd1;
                else if (up_e && !down_e)
                    d <= step_digit(d, cursor, 1'b1, m24_q);
                else if (down_e && !up_e)
                    d <= step_digit(d, cursor, 1'b0, m24_q);
            end else if (timeout) begin
                d         <= load_cur();
                blank     <= 1'b0;
                blink_cnt <= '0;
                idle_cnt  <= '0;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
                if (blink_cnt == BLINK_DIV - 1) begin
                    blank     <= ~blank;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 32'd1;
                end
            end
        end
    end

    assign bus.h1     = d.h1;
    assign bus.h0     = d.h0;
    assign bus.m1     = d.m1;
    assign bus.m0     = d.m0;
`ifdef SECONDS_EN
    assign bus.s1     = d.s1;
    assign bus.s0     = d.s0;
`endif
    assign bus.cursor = cursor;
    assign bus.blank  = blank;
    assign bus.commit = commit;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Parametrised time-setting controller for the watch datapath. It sits between the debounced front-panel buttons and the timekeeping counters. On entry to edit mode it loads the current time and walks a cursor across the digits. Up/down buttons step the selected digit within its legal range, in either 12-hour or 24-hour mode. On exit it presents the edited time with a one-cycle commit strobe, and an optional inactivity timeout can abandon an edit.

## Interface
- BLINK_DIV, 25_000_000: clock cycles per half-period of the selected-digit blank strobe (≥1)
- IDLE_TIMEOUT, 0: cycles without a button edge in EDIT before aborting without commit; 0 disables
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  debounced level; rising edge enters/leaves edit mode
- nextDigit  in  1  debounced level; rising edge advances cursor
- up / down  in  1 each  debounced levels; rising edge increments/decrements selected digit
- mode24  in  1  1 = 24-hour, 0 = 12-hour; sampled on EDIT entry
- cur_h1, cur_h0, cur_m1, cur_m0 (cur_s1, cur_s0 with SECONDS_EN)  in  4 each  live time, loaded on EDIT entry
- h1, h0, m1, m0 (s1, s0 with SECONDS_EN)  out  4 each  edit registers, BCD
- editing  out  1  high while in EDIT
- cursor  out  3  selected digit: 0=H1, 1=H0, 2=M1, 3=M0, 4=S1, 5=S0
- blank  out  1  display should blank the selected digit
- commit  out  1  one-cycle strobe; outputs hold committed time

## Operation
- Reset: IDLE; all digits 0, cursor 0, editing 0, blank 0, commit 0; edge-detect history 0; mode latch 1; counters 0.
- Edge = input high now and low on the previous clock; at most one action is taken per cycle.
- Priority: start > nextDigit > up > down. When up and down edges coincide, the digit is unchanged; the cycle still counts as activity.
- IDLE + start edge → EDIT: load cur_* into the digits, latch mode24, cursor=0, blank=0, clear the timers.
- In IDLE, edges on nextDigit, up and down are ignored.
- EDIT + start edge → IDLE with commit=1 for one cycle; the digits hold.
- EDIT + nextDigit edge: cursor+1, wrapping from LAST (3, or 5 with SECONDS_EN) to 0.
- EDIT + up/down: the selected digit steps ±1, wrapping between its min and max.
- Minute and second digit ranges: M1/S1 0–5; M0/S0 0–9.
- Hour ranges in 24-hour mode: H1 0–2; H0 0–9, or 0–3 when H1=2.
- Hour ranges in 12-hour mode: H1 0–1; H0 1–9 when H1=0, or 0–2 when H1=1.
- After an H1 step, H0 is normalised in the same cycle: clamp to the new max if above it; in 12-hour mode with H1=0 and H0=0, set H0=1.
- cur_* are trusted valid; no normalisation happens at load.
- Blank timer: counts only in EDIT; blank toggles every BLINK_DIV cycles. Any accepted edge forces blank=0 and restarts the count. In IDLE, blank=0.
- Timeout, when IDLE_TIMEOUT>0: after IDLE_TIMEOUT consecutive EDIT cycles with no edge, return to IDLE with no commit and reload the digits from cur_*.
- Reset mid-edit: the edit is abandoned immediately, with no commit.

## Timing
- Latency 1: an edge sampled at clock n updates the outputs after clock n; commit is high exactly in the cycle following the start-edge clock.
- A button held high gives one action only; the next action requires a low cycle first.
- Back-to-back edges on alternating cycles are all accepted.
- editing rises/falls in the same cycle as the state change.

## Configuration
- SECONDS_EN defined: adds the S1/S0 ports, cur_s1/cur_s0 and cursor positions 4–5; the cursor wraps at 5.
- SECONDS_EN undefined: no seconds ports; the cursor wraps at 3; cursor values 4–5 are never produced.

## Structure
- Package time_set_pkg: cursor position constants (CUR_H1…CUR_S0), digit max/min constants, state encoding (IDLE, EDIT).
- Sub-module edge_detect: per-button registered rising-edge detector with async reset. The top instantiates one per button.
- Digit step/normalise logic stays inline in the top as a function.

## Test plan
- Reset with cur=12:34, mode24=1, start edge → editing=1; h1..m0=1,2,3,4; cursor=0; no commit.
- 24-hour: digits 19:xx, cursor H1, up → 29 clamped to 23; up again → H1 wraps to 0 giving 03.
- 12-hour: load 10:00 → down on H1 gives 00 normalised to 01; cursor to H0, down → H0 wraps to 9 (09).
- Cursor: 5 nextDigit edges without SECONDS_EN → cursor 1,2,3,0,1. With SECONDS_EN, 7 edges end at cursor 1.
- start held high 10 cycles in EDIT → single commit pulse, one cycle wide, then IDLE. up and down rising in the same cycle → digit unchanged.
- IDLE_TIMEOUT=100, BLINK_DIV=4: blank toggles every 4 cycles; no input for 100 cycles → IDLE, commit never asserts, digits reloaded. Reset asserted mid-edit → all outputs 0 asynchronously.
